// File: rtl/fa_st.sv
// rtl/fa_st.sv - registered ripple-carry adder built from half-adder/full-adder cells
//
// fa_st_ha : one-bit half adder (XOR sum, AND carry).
// fa_st_fa : one-bit full adder from two half adders plus an OR carry merge.
// fa_st    : WIDTH-bit ripple chain of fa_st_fa cells with a registered result.
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   a      in   WIDTH  addend A
//   b      in   WIDTH  addend B
//   cin    in   1      carry into bit 0
//   s      out  WIDTH  registered sum, low WIDTH bits of a+b+cin
//   c      out  1      registered carry out of bit WIDTH-1

module fa_st_ha (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module fa_st_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  fa_st_ha u_ha0 (.i_x(i_a),  .i_y(i_b), .o_s(w_s0), .o_c(w_c0));
  fa_st_ha u_ha1 (.i_x(w_s0), .i_y(i_c), .o_s(o_s),  .o_c(w_c1));

  // Both half-adder carries can never be 1 together, so OR is an exact merge.
  assign o_c = w_c0 | w_c1;
endmodule

module fa_st #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c
);
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] r_s;
  logic             r_c;

  // Each stage owns its carry nets so the chain is not one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_first
      assign w_ci = cin;
    end else begin : g_next
      assign w_ci = g_bit[i-1].w_co;
    end

    fa_st_fa u_fa (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_ci),
      .o_s (w_sum[i]),
      .o_c (w_co)
    );
  end

  assign w_cout = g_bit[WIDTH-1].w_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= '0;
      r_c <= 1'b0;
    end else begin
      r_s <= w_sum;
      r_c <= w_cout;
    end
  end

  assign s = r_s;
  assign c = r_c;
endmodule

// File: tb/tb_fa_st.sv
// tb/tb_fa_st.sv - scoreboard bench for fa_st at WIDTH 1, 8 and 16

module tb_fa_st;
  logic        clk;
  logic        rst_n;

  logic [0:0]  a1, b1, s1;
  logic        cin1, c1;
  logic [7:0]  a8, b8, s8;
  logic        cin8, c8;
  logic [15:0] a16, b16, s16;
  logic        cin16, c16;

  int n_chk;
  int n_pass;

  logic [1:0]  q1[$];
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  fa_st #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .s(s1), .c(c1)
  );
  fa_st #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .s(s8), .c(c8)
  );
  fa_st #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .s(s16), .c(c16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Push the expected result for the inputs present now, clock once, then
  // pop and compare against what the DUTs registered at that edge.
  task automatic tick();
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [16:0] e16;
    if (rst_n) begin
      q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      q8.push_back({1'b0, a8} + {1'b0, b8} + {8'b0, cin8});
      q16.push_back({1'b0, a16} + {1'b0, b16} + {16'b0, cin16});
    end else begin
      q1.push_back('0);
      q8.push_back('0);
      q16.push_back('0);
    end
    @(posedge clk);
    #1;
    if (q1.size() == 0 || q8.size() == 0 || q16.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e1  = q1.pop_front();
      e8  = q8.pop_front();
      e16 = q16.pop_front();
      check_eq("w1_sum",  {30'b0, c1, s1},  {30'b0, e1});
      check_eq("w8_sum",  {23'b0, c8, s8},  {23'b0, e8});
      check_eq("w16_sum", {15'b0, c16, s16}, {15'b0, e16});
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq(tag, {15'b0, c16, s16, c8, s8, c1, s1}, 32'd0);
  endtask

  // {s,c} for (a,b,cin) = 000..111
  logic [1:0] tbl [8];
  logic [2:0] v;
  logic [8:0] prev8;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    a1 = '0; b1 = '0; cin1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    rst_n = 1'b1;

    // Reset takes effect before the first clock edge.
    #1 rst_n = 1'b0;
    #1 check_zero("reset_async");
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; a8 = 8'hAA; a16 = 16'h1234;
    tick();
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep against the truth table.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      tick();
      check_eq("w1_tbl", {30'b0, s1, c1}, {30'b0, tbl[i]});
    end

    // Wrap-around and full-chain carry at WIDTH=8.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    tick();
    check_eq("w8_wrap", {23'b0, c8, s8}, 32'h100);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    check_eq("w8_chain", {23'b0, c8, s8}, 32'h1FF);

    // Inputs change twice between edges: outputs hold, then take the last values.
    prev8 = {c8, s8};
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    #2 check_eq("w8_hold1", {23'b0, c8, s8}, {23'b0, prev8});
    a8 = 8'h80; b8 = 8'h81; cin8 = 1'b1;
    #2 check_eq("w8_hold2", {23'b0, c8, s8}, {23'b0, prev8});
    tick();
    check_eq("w8_last", {23'b0, c8, s8}, 32'h102);

    // Reset asserted between edges drops the registered result at once.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    tick();
    check_eq("w1_111", {30'b0, c1, s1}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    q1.delete(); q8.delete(); q16.delete();
    tick();
    check_zero("reset_mid_held");
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("w1_resume", {30'b0, c1, s1}, 32'd3);

    // Back-to-back random vectors on all widths.
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
      a1  = 1'($urandom);  b1  = 1'($urandom);  cin1  = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
